// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM encoding, bus widths, byte enables.
package lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [BE_W-1:0] BE_WORD = 4'hF;
  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;

  // Byte accesses can sit in any lane; word accesses must be 4-byte aligned.
  function automatic logic is_misaligned(input logic mem_byte, input logic [1:0] lo);
    return !mem_byte && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational little-endian byte-lane steering: store enables/replication and
// zero-extended byte extraction for loads.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic            st_byte,
  input  logic [1:0]      st_lo,
  input  logic [XLEN-1:0] st_data,
  input  logic            ld_byte,
  input  logic [1:0]      ld_lo,
  input  logic [XLEN-1:0] ld_data,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [7:0] ld_sel;

  always_comb begin
    be    = st_byte ? (BE_BYTE << st_lo) : BE_WORD;
    wdata = st_byte ? {4{st_data[7:0]}} : st_data;
  end

  always_comb begin
    ld_sel = ld_data[7:0];
    case (ld_lo)
      2'd1:    ld_sel = ld_data[15:8];
      2'd2:    ld_sel = ld_data[23:16];
      2'd3:    ld_sel = ld_data[31:24];
      default: ld_sel = ld_data[7:0];
    endcase
    rdata = ld_byte ? {{(XLEN-8){1'b0}}, ld_sel} : ld_data;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: req/ack bus master that stalls the core while a transfer is open.
// Optional LSU_WBUF_EN adds a one-entry posted write buffer drained in the background.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemByte,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            Misalign,
  output logic            BusErr,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic            acc, mis, tmo, post, blocked, drain_err;
  logic            req_we, req_byte;
  logic [1:0]      req_lo;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [BE_W-1:0] req_be;
  logic [BE_W-1:0] lane_be;
  logic [XLEN-1:0] lane_wdata, lane_rdata;
  logic            mis_q, err_q;
  logic [XLEN-1:0] rdata_q;

  assign acc = MemRead | MemWrite;
  assign mis = is_misaligned(MemByte, Addr[1:0]);

  lsu_lane u_lane (
    .st_byte (MemByte),
    .st_lo   (Addr[1:0]),
    .st_data (WriteData),
    .ld_byte (req_byte),
    .ld_lo   (req_lo),
    .ld_data (bus_rdata),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .rdata   (lane_rdata)
  );

  // One timeout counter serves whichever transfer currently owns the bus.
  assign tmo = bus_req && !bus_ack && (TIMEOUT != 0) && (cnt == CNT_LAST);

`ifdef LSU_WBUF_EN
  logic            wb_full;
  logic [XLEN-1:0] wb_addr, wb_wdata;
  logic [BE_W-1:0] wb_be;

  // Only aligned stores are posted; misaligned ones take the blocking path to flag Misalign.
  assign post      = (state == S_IDLE) && MemWrite && !mis && !wb_full;
  assign blocked   = wb_full;
  assign drain_err = wb_full && tmo;

  assign bus_req   = wb_full || (state == S_REQ);
  assign bus_we    = wb_full ? 1'b1     : req_we;
  assign bus_addr  = wb_full ? wb_addr  : req_addr;
  assign bus_be    = wb_full ? wb_be    : req_be;
  assign bus_wdata = wb_full ? wb_wdata : req_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_full  <= 1'b0;
      wb_addr  <= '0;
      wb_be    <= '0;
      wb_wdata <= '0;
    end else if (post) begin
      wb_full  <= 1'b1;
      wb_addr  <= {Addr[XLEN-1:2], 2'b00};
      wb_be    <= lane_be;
      wb_wdata <= lane_wdata;
    end else if (wb_full && (bus_ack || tmo)) begin
      wb_full  <= 1'b0;
    end
  end
`else
  assign post      = 1'b0;
  assign blocked   = 1'b0;
  assign drain_err = 1'b0;

  assign bus_req   = (state == S_REQ);
  assign bus_we    = req_we;
  assign bus_addr  = req_addr;
  assign bus_be    = req_be;
  assign bus_wdata = req_wdata;
`endif

  assign Stall    = acc && (state != S_DONE) && !post;
  assign Misalign = mis_q;
  assign BusErr   = err_q | drain_err;
  assign ReadData = rdata_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc && !blocked && !post) state_nxt = mis ? S_DONE : S_REQ;
      S_REQ:   if (bus_ack || tmo) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_byte  <= 1'b0;
      req_lo    <= 2'b00;
      req_addr  <= '0;
      req_be    <= '0;
      req_wdata <= '0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      if (!bus_req || bus_ack || tmo) cnt <= '0;
      else                            cnt <= cnt + 1'b1;

      // Capture the access at IDLE exit; the core holds its inputs while stalled.
      if ((state == S_IDLE) && (state_nxt != S_IDLE)) begin
        req_we    <= MemWrite;
        req_byte  <= MemByte;
        req_lo    <= Addr[1:0];
        req_addr  <= {Addr[XLEN-1:2], 2'b00};
        req_be    <= lane_be;
        req_wdata <= lane_wdata;
        if (mis) begin
          mis_q   <= 1'b1;
          rdata_q <= '0;
        end
      end

      if ((state == S_REQ) && (state_nxt == S_DONE)) begin
        err_q   <= tmo;
        rdata_q <= (bus_ack && !req_we) ? lane_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu (TIMEOUT=4); adapts store expectations when LSU_WBUF_EN is defined.
module tb_lsu;

`ifdef LSU_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemByte = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, Misalign, BusErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          n_chk = 0, n_pass = 0;
  int          ack_delay = 0;
  logic [31:0] rd_val = '0;
  logic        force_ack = 1'b0;
  int          req_cycles = 0, req_seen = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chk_rd;
    logic        mis;
    logic        err;
    int          stalls;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemByte   (MemByte),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Misalign  (Misalign),
    .BusErr    (BusErr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  // Bus slave: acks after ack_delay request cycles (negative = never), records fields at ack.
  always @(negedge clk) begin
    bus_rdata = rd_val;
    if (bus_req) begin
      req_seen++;
      bus_ack = (ack_delay >= 0) && (req_cycles == ack_delay);
      if (bus_ack) begin
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
        cap_be    = bus_be;
        cap_we    = bus_we;
      end
      req_cycles++;
    end else begin
      bus_ack    = force_ack;
      req_cycles = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Called just after a rising edge; returns just after the edge that commits the access.
  task automatic access(input string tag, input logic rd, input logic wr, input logic by,
                        input logic [31:0] addr, input logic [31:0] wd, input int dly,
                        input logic [31:0] rv, input logic [31:0] erd, input bit chk_rd,
                        input logic emis, input logic eerr, input int estl);
    exp_t e;
    int   stl;
    bit   done;
    e.tag = tag; e.rdata = erd; e.chk_rd = chk_rd; e.mis = emis; e.err = eerr; e.stalls = estl;
    sbq.push_back(e);
    ack_delay = dly;
    rd_val    = rv;
    MemRead = rd; MemWrite = wr; MemByte = by; Addr = addr; WriteData = wd;
    stl  = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (Stall) stl++;
      else done = 1;
    end
    e = sbq.pop_front();
    if (!done) chk({e.tag, "_no_completion"}, 32'd0, 32'd1);
    if (e.chk_rd) chk({e.tag, "_rdata"}, ReadData, e.rdata);
    chk({e.tag, "_misalign"}, Misalign, e.mis);
    chk({e.tag, "_buserr"}, BusErr, e.err);
    chk({e.tag, "_stalls"}, stl, e.stalls);
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Lets a posted store drain before the next access.
  task automatic settle();
    if (WBUF) repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_misalign", Misalign, 1'b0);
    chk("rst_buserr", BusErr, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    access("ldr_100", 1, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 2);
    chk("ldr_100_addr", cap_addr, 32'h100);
    chk("ldr_100_be", cap_be, 4'hF);
    chk("ldr_100_we", cap_we, 1'b0);

    access("strb_203", 0, 1, 1, 32'h203, 32'h5A, 0, 0, 32'h0, !WBUF, 0, 0, WBUF ? 0 : 2);
    settle();
    chk("strb_203_be", cap_be, 4'b1000);
    chk("strb_203_wdata", cap_wdata, 32'h5A5A5A5A);
    chk("strb_203_addr", cap_addr, 32'h200);
    chk("strb_203_we", cap_we, 1'b1);

    access("ldrb_102", 1, 0, 1, 32'h102, 0, 0, 32'h11223344, 32'h22, 1, 0, 0, 2);
    chk("ldrb_102_be", cap_be, 4'b0100);
    access("ldrb_101", 1, 0, 1, 32'h101, 0, 0, 32'h11223344, 32'h33, 1, 0, 0, 2);
    access("ldrb_103", 1, 0, 1, 32'h103, 0, 1, 32'hA1B2C3D4, 32'hA1, 1, 0, 0, 3);

    base = req_seen;
    access("ldr_mis", 1, 0, 0, 32'h101, 0, 0, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 1);
    chk("ldr_mis_no_bus", req_seen - base, 0);
    @(negedge clk);
    chk("ldr_mis_pulse_end", Misalign, 1'b0);
    @(posedge clk);
    #1;

    base = req_seen;
    access("str_mis", 0, 1, 0, 32'h102, 32'h12345678, 0, 0, 32'h0, 1, 1, 0, 1);
    chk("str_mis_no_bus", req_seen - base, 0);

    access("str_300", 0, 1, 0, 32'h300, 32'h12345678, 2, 0, 32'h0, !WBUF, 0, 0, WBUF ? 0 : 4);
    settle();
    chk("str_300_wdata", cap_wdata, 32'h12345678);
    chk("str_300_be", cap_be, 4'hF);

    access("rw_both", 1, 1, 0, 32'h400, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 32'h0, !WBUF, 0, 0, WBUF ? 0 : 2);
    settle();
    chk("rw_both_we", cap_we, 1'b1);
    chk("rw_both_wdata", cap_wdata, 32'hCAFEF00D);

    access("ldr_104", 1, 0, 0, 32'h104, 0, 0, 32'h55AA55AA, 32'h55AA55AA, 1, 0, 0, 2);
    @(negedge clk);
    chk("readdata_hold", ReadData, 32'h55AA55AA);
    @(posedge clk);
    #1;

    base = req_seen;
    access("ldr_tmo", 1, 0, 0, 32'h500, 0, -1, 32'h77777777, 32'h0, 1, 0, 1, 5);
    chk("ldr_tmo_req_cycles", req_seen - base, 4);
    @(negedge clk);
    chk("ldr_tmo_pulse_end", BusErr, 1'b0);
    chk("ldr_tmo_req_low", bus_req, 1'b0);
    @(posedge clk);
    #1;

`ifdef LSU_WBUF_EN
    access("wb_str", 0, 1, 0, 32'h700, 32'h0BADF00D, 3, 0, 32'h0, 0, 0, 0, 0);
    access("wb_ldr_after_str", 1, 0, 0, 32'h704, 0, 3, 32'h13572468, 32'h13572468, 1, 0, 0, 9);
`endif

    // Reset while a load is waiting in REQ, then a stray ack in IDLE.
    ack_delay = -1;
    MemRead = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h600;
    @(negedge clk);
    @(negedge clk);
    chk("rst_inreq_req_high", bus_req, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    chk("rst_inreq_req_low", bus_req, 1'b0);
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", bus_req, 1'b0);
    chk("late_ack_readdata", ReadData, 32'h0);
    chk("late_ack_buserr", BusErr, 1'b0);
    chk("late_ack_stall", Stall, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
